systolic_result_collector: RTL and testbench

- Drain-side counterpart of the operand feeder for the 3x3 systolic array. Captures the nine 32-bit PE accumulator results of one output tile and writes them into the matching quadrant of a 6x6 result matrix C.
- The quadrant is chosen by the same 2-bit select used to feed A/B. Once tiles are stored, streams the full C matrix out in row-major order over a valid/ready handshake.

---
 rtl/systolic_result_collector_pkg.sv | 25 ++
 rtl/systolic_result_collector_ram.sv | 45 ++++
 rtl/systolic_result_collector.sv | 165 ++++++++++++++++
 tb/tb_systolic_result_collector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_collector_pkg.sv
// Shared sizes, FSM encoding and quadrant-to-base mapping for the result collector.
package systolic_result_collector_pkg;

  localparam int DATA_W   = 32;
  localparam int TILE_N   = 3;
  localparam int MAT_N    = 2 * TILE_N;
  localparam int IDX_W    = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_N * MAT_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // select bit1 picks the row half, bit0 the column half
  function automatic logic [2:0] quad_rbase(input logic [1:0] sel);
    return sel[1] ? 3'(TILE_N) : 3'd0;
  endfunction

  function automatic logic [2:0] quad_cbase(input logic [1:0] sel);
    return sel[0] ? 3'(TILE_N) : 3'd0;
  endfunction

endpackage

// File: rtl/systolic_result_collector_ram.sv
// 36-entry result register file: one 3-wide row write per cycle, one registered read.
// Synchronous reset clears every entry and the read register.
module result_matrix_ram #(
  parameter int DATA_W = 32,
  parameter int TILE_N = 3,
  parameter int MAT_N  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [2:0]               wr_row,
  input  logic [2:0]               wr_col,
  input  logic [TILE_N*DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [5:0]               rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  import systolic_result_collector_pkg::*;

  logic [DATA_W-1:0] mem [MAT_N*MAT_N];
  logic [5:0]        wr_base;

  always_comb begin
    wr_base = {3'b000, wr_row} * 6'(MAT_N) + {3'b000, wr_col};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAT_N * MAT_N; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int j = 0; j < TILE_N; j++) begin
          mem[wr_base + 6'(j)] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Captures one 3x3 PE result tile into a quadrant of the 6x6 C matrix (3 row writes),
// and streams C out row-major over valid/ready; index advances only on accepted beats.
module systolic_result_collector #(
  parameter int DATA_W = 32,
  parameter int TILE_N = 3,
  parameter int MAT_N  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        select,
  input  logic              capture,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c02,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  input  logic [DATA_W-1:0] c12,
  input  logic [DATA_W-1:0] c20,
  input  logic [DATA_W-1:0] c21,
  input  logic [DATA_W-1:0] c22,
  input  logic              drain_req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              tile_done,
  output logic [3:0]        tile_valid,
  output logic              all_valid,
  output logic              busy
);
  import systolic_result_collector_pkg::*;

  state_t                   state_q, state_d;
  logic [1:0]               row_q;
  logic [IDX_W-1:0]         idx_q;
  logic [1:0]               sel_q;
  logic [DATA_W-1:0]        tile_q [TILE_N*TILE_N];
  logic [3:0]               tile_valid_q;
  logic                     tile_done_q;

  logic                     wr_en;
  logic [TILE_N*DATA_W-1:0] wr_data;
  logic                     rd_en;
  logic [IDX_W-1:0]         rd_addr;
  logic                     fire;

  assign fire = (state_q == ST_DRAIN) && out_ready;

  always_comb begin
    case (row_q)
      2'd0:    wr_data = {tile_q[2], tile_q[1], tile_q[0]};
      2'd1:    wr_data = {tile_q[5], tile_q[4], tile_q[3]};
      default: wr_data = {tile_q[8], tile_q[7], tile_q[6]};
    endcase
  end

  // Read port is primed one element ahead so out_data is ready the cycle after a transfer.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_CAPTURE;
        end else if (drain_req) begin
          state_d = ST_DRAIN;
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (row_q == 2'd2) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = idx_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      tile_valid_q <= '0;
      tile_done_q  <= 1'b0;
      for (int i = 0; i < TILE_N * TILE_N; i++) begin
        tile_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tile_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            sel_q     <= select;
            row_q     <= '0;
            tile_q[0] <= c00;
            tile_q[1] <= c01;
            tile_q[2] <= c02;
            tile_q[3] <= c10;
            tile_q[4] <= c11;
            tile_q[5] <= c12;
            tile_q[6] <= c20;
            tile_q[7] <= c21;
            tile_q[8] <= c22;
          end else if (drain_req) begin
            idx_q <= '0;
          end
        end
        ST_CAPTURE: begin
          row_q <= row_q + 2'd1;
          if (row_q == 2'd2) begin
            tile_valid_q[sel_q] <= 1'b1;
            tile_done_q         <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            idx_q <= idx_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  result_matrix_ram #(
    .DATA_W (DATA_W),
    .TILE_N (TILE_N),
    .MAT_N  (MAT_N)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_row  (quad_rbase(sel_q) + {1'b0, row_q}),
    .wr_col  (quad_cbase(sel_q)),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign out_valid  = (state_q == ST_DRAIN);
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign busy       = (state_q != ST_IDLE);
  assign tile_done  = tile_done_q;
  assign tile_valid = tile_valid_q;
  assign all_valid  = &tile_valid_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench: a 6x6 array model supplies expected drain beats; a negedge monitor checks them.
module tb_systolic_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  select = '0;
  logic        capture = 1'b0;
  logic [31:0] c [9];
  logic        drain_req = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_last, tile_done, all_valid, busy;
  logic [31:0] out_data;
  logic [3:0]  tile_valid;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] model [6][6];
  logic [3:0]  tv_model = '0;
  int          errors = 0;
  int          checks = 0;
  int          beats = 0;
  int          ready_mode = 0;
  int          rdy_phase = 0;

  always #5 clk = ~clk;

  systolic_result_collector dut (
    .clk(clk), .reset(reset), .select(select), .capture(capture),
    .c00(c[0]), .c01(c[1]), .c02(c[2]), .c10(c[3]), .c11(c[4]), .c12(c[5]),
    .c20(c[6]), .c21(c[7]), .c22(c[8]),
    .drain_req(drain_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .tile_done(tile_done),
    .tile_valid(tile_valid), .all_valid(all_valid), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid cycle is compared against the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h with empty scoreboard at %0t", out_data, $time);
      end else begin
        check("drain_data", out_data, exp_q[0].d);
        check("drain_last", 32'(out_last), 32'(exp_q[0].l));
        if (out_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++)
        model[r][k] = '0;
    tv_model = '0;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++)
        exp_q.push_back('{d: model[r][k], l: (r == 5 && k == 5)});
  endtask

  task automatic randomize_inputs();
    select = 2'($urandom_range(0, 3));
    for (int i = 0; i < 9; i++) c[i] = $urandom;
  endtask

  // Capture a tile; with_drain also raises drain_req in the same cycle (capture must win).
  task automatic do_capture(input logic [1:0] sel, input logic [31:0] v [9], input bit with_drain);
    int lat;
    select = sel;
    c = v;
    capture = 1'b1;
    drain_req = with_drain;
    tick();
    capture = 1'b0;
    drain_req = 1'b0;
    randomize_inputs();
    lat = 1;
    while (!tile_done && lat < 10) begin
      tick();
      lat++;
    end
    check("tile_done_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 9; i++) model[(sel[1] ? 3 : 0) + i / 3][(sel[0] ? 3 : 0) + i % 3] = v[i];
    tv_model[sel] = 1'b1;
    check("tile_valid", 32'(tile_valid), 32'(tv_model));
    check("all_valid", 32'(all_valid), 32'(&tv_model));
    tick();
    check("tile_done_pulse", 32'(tile_done), 32'd0);
    check("idle_after_capture", 32'(busy | out_valid), 32'd0);
  endtask

  task automatic do_drain(input int mode, input bit inject);
    int start, cyc;
    bit injd;
    ready_mode = mode;
    push_expected();
    start = beats;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    cyc = 0;
    injd = 0;
    while (beats < start + 36 && cyc < 500) begin
      if (inject && !injd && beats >= start + 5) begin
        randomize_inputs();
        capture = 1'b1;
        injd = 1;
      end else begin
        capture = 1'b0;
      end
      tick();
      cyc++;
    end
    capture = 1'b0;
    check("drain_beats", 32'(beats - start), 32'd36);
    check("drain_leftover", 32'(exp_q.size()), 32'd0);
    check("drain_end_valid", 32'(out_valid), 32'd0);
    check("drain_end_busy", 32'(busy), 32'd0);
    check("tile_valid_after_drain", 32'(tile_valid), 32'(tv_model));
    ready_mode = 0;
  endtask

  function automatic void seq_vals(input logic [31:0] base, output logic [31:0] v [9]);
    for (int i = 0; i < 9; i++) v[i] = base + 32'(i);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [9];
    int cyc;
    for (int i = 0; i < 9; i++) c[i] = '0;
    clear_model();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_tile_done", 32'(tile_done), 32'd0);
    check("rst_tile_valid", 32'(tile_valid), 32'd0);
    check("rst_all_valid", 32'(all_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    do_drain(0, 0);

    seq_vals(32'd1, v);
    do_capture(2'b00, v, 0);
    do_drain(0, 0);

    seq_vals(32'd11, v);
    do_capture(2'b01, v, 0);
    seq_vals(32'd21, v);
    do_capture(2'b10, v, 0);
    seq_vals(32'd31, v);
    do_capture(2'b11, v, 0);
    do_drain(2, 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 9; i++) v[i] = $urandom;
      do_capture(2'($urandom_range(0, 3)), v, 0);
    end
    do_drain(1, 0);

    // Simultaneous capture/drain_req: capture wins, drain dropped (monitor flags any beat).
    for (int i = 0; i < 9; i++) v[i] = $urandom;
    do_capture(2'b10, v, 1);
    repeat (3) tick();
    check("dropped_drain_valid", 32'(out_valid), 32'd0);

    do_drain(1, 1);
    do_drain(0, 0);

    // Reset mid-drain at beat 10.
    push_expected();
    cyc = beats;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    while (beats < cyc + 10 && beats < cyc + 36) tick();
    reset = 1'b1;
    exp_q.delete();
    clear_model();
    tick();
    reset = 1'b0;
    check("drain_abort_valid", 32'(out_valid), 32'd0);
    check("drain_abort_busy", 32'(busy), 32'd0);
    check("drain_abort_tv", 32'(tile_valid), 32'd0);
    check("drain_abort_data", out_data, 32'd0);
    do_drain(0, 0);

    // Reset during CAPTURE row 1.
    for (int i = 0; i < 9; i++) v[i] = $urandom;
    do_capture(2'b11, v, 0);
    select = 2'b00;
    for (int i = 0; i < 9; i++) c[i] = $urandom | 32'h1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
    reset = 1'b1;
    clear_model();
    tick();
    reset = 1'b0;
    check("cap_abort_busy", 32'(busy), 32'd0);
    check("cap_abort_valid", 32'(out_valid), 32'd0);
    check("cap_abort_tv", 32'(tile_valid), 32'd0);
    repeat (4) tick();
    check("cap_abort_no_done", 32'(tile_done), 32'd0);
    do_drain(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
